// File: rtl/bcd_button_counter.sv
// Two debounced pushbuttons step a pair of 4-digit packed-BCD counters in
// opposite directions; feeds the dual 7-segment display controller.
module bcd_button_counter #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [15:0] A_INIT          = 16'h0000,
    parameter logic [15:0] B_INIT          = 16'h9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        clear,
    output logic [15:0] digits_A,
    output logic [15:0] digits_B,
    output logic        step_pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // index 0 = up, index 1 = down
    logic [1:0]    btn_m, btn_s, btn_db, db_prev, press;
    logic [CW-1:0] cnt [2];

    logic [15:0] next_a, next_b;
    logic        next_step;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic c;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) v[4*i +: 4] = 4'd0;
                else begin
                    v[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return v;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic b;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) v[4*i +: 4] = 4'd9;
                else begin
                    v[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return v;
    endfunction

    // Sync, debounce and rising-edge press detect for both buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m   <= '0;
            btn_s   <= '0;
            btn_db  <= '0;
            db_prev <= '0;
            press   <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            btn_m   <= {btn_down, btn_up};
            btn_s   <= btn_m;
            db_prev <= btn_db;
            press   <= btn_db & ~db_prev;
            for (int i = 0; i < 2; i++) begin
                if (btn_s[i] == btn_db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_db[i] <= btn_s[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_a    = digits_A;
        next_b    = digits_B;
        next_step = 1'b0;
        if (clear) begin
            next_a = A_INIT;
            next_b = B_INIT;
        end else if (press == 2'b01) begin
            next_a    = bcd_inc(digits_A);
            next_b    = bcd_dec(digits_B);
            next_step = 1'b1;
        end else if (press == 2'b10) begin
            next_a    = bcd_dec(digits_A);
            next_b    = bcd_inc(digits_B);
            next_step = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_A   <= A_INIT;
            digits_B   <= B_INIT;
            step_pulse <= 1'b0;
        end else begin
            digits_A   <= next_a;
            digits_B   <= next_b;
            step_pulse <= next_step;
        end
    end
endmodule

// File: tb/tb_bcd_button_counter.sv
// Directed bench for bcd_button_counter with DEBOUNCE_CYCLES=4.
module tb_bcd_button_counter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits_A, digits_B;
    logic        step_pulse;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int steps = 0;
    int last_step = 0;
    int t0 = 0;

    bcd_button_counter #(
        .DEBOUNCE_CYCLES(4),
        .A_INIT(16'h0000),
        .B_INIT(16'h9999)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .clear(clear), .digits_A(digits_A), .digits_B(digits_B),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (step_pulse) begin
        steps     = steps + 1;
        last_step = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic dn);
        tick(1);
        t0 = cyc;
        btn_up = up;
        btn_down = dn;
        tick(20);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(12);
    endtask

    // Bounce pattern: alternating high/low run lengths, all shorter than 4.
    int runs [16] = '{1, 2, 3, 1, 2, 3, 3, 1, 1, 2, 3, 2, 3, 3, 2, 1};

    initial begin
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_a", digits_A, 16'h0000);
        check("reset_b", digits_B, 16'h9999);
        check("reset_step", step_pulse, 1'b0);

        // reset mid-debounce discards the partial count
        steps = 0;
        btn_up = 1'b1;
        tick(4);
        rst = 1'b1;
        btn_up = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(15);
        check("rst_mid_steps", steps, 0);
        check("rst_mid_a", digits_A, 16'h0000);

        // held through reset: one press after full debounce
        btn_up = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(20);
        btn_up = 1'b0;
        tick(12);
        check("rst_held_steps", steps, 1);
        check("rst_held_a", digits_A, 16'h0001);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);

        // single up press, with latency window
        steps = 0;
        press(1'b1, 1'b0);
        check("single_steps", steps, 1);
        check("single_a", digits_A, 16'h0001);
        check("single_b", digits_B, 16'h9998);
        check("latency", ((last_step - t0) >= 7 && (last_step - t0) <= 9), 1'b1);

        // carry / borrow
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
        check("carry_steps", steps, 10);
        check("carry_a", digits_A, 16'h0010);
        check("carry_b", digits_B, 16'h9989);
        press(1'b0, 1'b1);
        check("borrow_a", digits_A, 16'h0009);
        check("borrow_b", digits_B, 16'h9990);

        // wrap
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clear_a", digits_A, 16'h0000);
        check("clear_b", digits_B, 16'h9999);
        press(1'b0, 1'b1);
        check("wrap_dn_a", digits_A, 16'h9999);
        check("wrap_dn_b", digits_B, 16'h0000);
        press(1'b1, 1'b0);
        check("wrap_up_a", digits_A, 16'h0000);
        check("wrap_up_b", digits_B, 16'h9999);

        // bounce
        steps = 0;
        for (int i = 0; i < 16; i++) begin
            btn_up = (i % 2 == 0);
            tick(runs[i]);
        end
        btn_up = 1'b0;
        tick(10);
        check("bounce_steps", steps, 0);
        check("bounce_a", digits_A, 16'h0000);
        press(1'b1, 1'b0);
        check("bounce_hold_steps", steps, 1);
        check("bounce_hold_a", digits_A, 16'h0001);

        // both buttons together
        steps = 0;
        press(1'b1, 1'b1);
        check("both_steps", steps, 0);
        check("both_a", digits_A, 16'h0001);
        check("both_b", digits_B, 16'h9998);

        // clear covering the press_up cycle drops the press
        steps = 0;
        tick(1);
        btn_up = 1'b1;
        tick(5);
        clear = 1'b1;
        tick(5);
        clear = 1'b0;
        tick(10);
        btn_up = 1'b0;
        tick(12);
        check("clr_press_steps", steps, 0);
        check("clr_press_a", digits_A, 16'h0000);
        check("clr_press_b", digits_B, 16'h9999);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
